// File: rtl/calc_pkg.sv
// Shared definitions for the calculator ALU result formatter:
// op codes, the blank BCD code and the formatter FSM state encoding.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the next magnitude bit in at the bottom.
module bcd_dd_step
  import calc_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] bcd_out
);

  localparam int BW = 4 * DIGITS;

  logic [BW-1:0] adj_s;

  // Per-nibble add-3 correction followed by the 1-bit shift.
  always_comb begin
    adj_s = bcd_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_in[4*i +: 4];
      end
    end
    // The top bit shifted out is always zero when 10^DIGITS > 2^RES_W - 1.
    bcd_out = BW'({adj_s, bit_in});
  end

endmodule

// File: rtl/alu_result_formatter.sv
// ALU result formatter: accepts one ALU word, converts its magnitude to BCD
// with a sequential double-dabble engine (RES_W clocks) and presents signed
// digits with error/status flags to the display driver.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits
// above digit 0 for non-Div results).
module alu_result_formatter
  import calc_pkg::*;
#(
  parameter int RES_W  = 4,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RES_W-1:0]    in_result,
  input  logic                in_status,
  input  logic [1:0]          in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_digits,
  output logic                out_neg,
  output logic                out_err,
  output logic                out_flag,
  output logic [1:0]          out_op
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = (RES_W > 1) ? $clog2(RES_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_W - 1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [RES_W-1:0]   mag_r;
  logic [RES_W-1:0]   res_r;
  logic [BW-1:0]      bcd_r;

  logic [RES_W-1:0]   sel_mag_s;
  logic               sel_neg_s;
  logic [BW-1:0]      step_s;
  logic [BW-1:0]      div_s;
  logic [BW-1:0]      final_s;

`ifdef LEADING_ZERO_BLANK_EN
  // Replace zero digits above digit 0 with blanks until a non-zero is seen.
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] d);
    logic lead;
    lead     = 1'b1;
    blank_lz = d;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) begin
        blank_lz[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  endfunction
`endif

  bcd_dd_step #(.DIGITS(DIGITS)) u_step (
    .bcd_in  (bcd_r),
    .bit_in  (mag_r[RES_W-1]),
    .bcd_out (step_s)
  );

  // Magnitude and sign selection for the word being accepted.
  always_comb begin
    sel_mag_s = in_result;
    sel_neg_s = 1'b0;
    case (in_op)
      OP_SUB: begin
        if (in_result[RES_W-1]) begin
          sel_mag_s = ~in_result + RES_W'(1);
          sel_neg_s = 1'b1;
        end else begin
          sel_mag_s = in_result;
          sel_neg_s = 1'b0;
        end
      end
      default: begin
        sel_mag_s = in_result;
        sel_neg_s = 1'b0;
      end
    endcase
  end

  // Final digit pattern loaded on the last conversion iteration.
  always_comb begin
    div_s            = '0;
    div_s[3:0]       = {2'b00, res_r[1:0]};
    div_s[7:4]       = {2'b00, res_r[3:2]};
    final_s          = step_s;
    if (out_op == OP_DIV) begin
      if (out_err) begin
        final_s = {DIGITS{BCD_BLANK}};
      end else begin
        final_s = div_s;
      end
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      final_s = blank_lz(step_s);
`else
      final_s = step_s;
`endif
    end
  end

  // Handshake FSM, conversion engine state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      mag_r      <= '0;
      res_r      <= '0;
      bcd_r      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_digits <= '0;
      out_neg    <= 1'b0;
      out_err    <= 1'b0;
      out_flag   <= 1'b0;
      out_op     <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_r  <= CONV;
            cnt_r    <= '0;
            mag_r    <= sel_mag_s;
            res_r    <= in_result;
            bcd_r    <= '0;
            in_ready <= 1'b0;
            out_neg  <= sel_neg_s && (in_op == OP_SUB);
            out_err  <= (in_op == OP_DIV) && in_status;
            out_flag <= in_status;
            out_op   <= in_op;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CONV: begin
          bcd_r <= step_s;
          mag_r <= mag_r << 1;
          if (cnt_r == CNT_LAST) begin
            cnt_r      <= '0;
            state_r    <= DONE;
            out_valid  <= 1'b1;
            out_digits <= final_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_result_formatter.md
Name: alu_result_formatter

Overview:
Downstream stage of the 2-bit calculator ALU. Captures one ALU result word (result, status, op) through a valid/ready handshake and converts it to signed BCD digits with a sequential shift-add-3 (double-dabble) engine. Presents the digits, with sign and error flags, to the display driver through a second valid/ready handshake.

Parameters:
RES_W, 4, width of the ALU result bus
DIGITS, 2, number of BCD digits produced; must satisfy 10^DIGITS > 2^RES_W - 1

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ALU word present
in_ready  output  1  formatter idle and able to accept
in_result  input  RES_W  ALU result word
in_status  input  1  ALU status (carry/borrow/overflow/div0)
in_op  input  2  00=Add, 01=Sub, 10=Mul, 11=Div
out_valid  output  1  formatted word present
out_ready  input  1  display consumer accepts
out_digits  output  4*DIGITS  BCD digits; digit 0 in bits [3:0]; code 4'hF = blank
out_neg  output  1  value is negative (Sub only)
out_err  output  1  divide-by-zero error
out_flag  output  1  registered copy of in_status
out_op  output  2  registered copy of in_op

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst). While rst is high: state=IDLE, in_ready=0, out_valid=0, out_digits=0, out_neg=0, out_err=0, out_flag=0, out_op=0, counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready (the accept edge), capture the inputs and go to CONV.
  - CONV: in_ready=0. Perform one double-dabble iteration per clock: add 3 to every BCD nibble >= 5, then shift one magnitude bit in, MSB first. Exactly RES_W iterations, then go to DONE.
  - DONE: out_valid=1, outputs stable. On out_valid&out_ready, go to IDLE.
- Latency: out_valid rises RES_W clocks after the accept edge, for every op including error cases.
- Throughput: in_ready is high again the clock after an output transfer. There is no same-cycle in->out bypass. Minimum period is RES_W+2 clocks per word.
- Magnitude selection at the accept edge:
  - Add/Mul: magnitude = in_result; out_neg=0.
  - Sub: sign = in_result[RES_W-1]. If the sign is 1, magnitude = two's-complement negation of in_result and out_neg=1. Example: 4'b1101 gives magnitude 3, out_neg=1.
  - Div with status=0: digit 1 = zero-extended in_result[3:2] (remainder); digit 0 = zero-extended in_result[1:0] (quotient). The converter still runs its RES_W cycles to keep latency uniform; the remainder and quotient nibbles override its output.
  - Div with status=1: out_err=1, all digits 4'hF, out_neg=0.
- out_flag and out_op are captured at the accept edge and held through DONE.
- Boundary conditions:
  - in_valid while busy (CONV/DONE): ignored, nothing is captured; the upstream stage must hold its data.
  - out_ready held low: DONE persists indefinitely and outputs must not change.
  - Maximum magnitude 2^RES_W-1 (15): digits 1,5.
  - Sub result -2^(RES_W-1) (4'b1000): magnitude 8, out_neg=1.
  - Reset asserted in CONV or DONE: the conversion is aborted and no partial output is emitted.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in DONE, leading zero digits above digit 0 are replaced by 4'hF. Digit 0 is never blanked. Div digits are not blanked.
- Undefined: leading zeros are output as 4'h0.

Decomposition:
- Package calc_pkg holds:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - BCD_BLANK = 4'hF
  - FSM state enum (IDLE, CONV, DONE)
- Sub-module bcd_dd_step: combinational add-3 plus 1-bit shift for DIGITS nibbles. The top level holds the FSM, counter and registers.

Test Plan:
- Add, in_result=4'b0101, status=0 -> after 4 clocks out_digits=8'h05, out_neg=0; with LEADING_ZERO_BLANK_EN, 8'hF5.
- Add, in_result=4'b1111 (15) -> out_digits=8'h15, out_flag=in_status; Mul in_result=4'b1001, status=1 -> 8'h09, out_flag=1.
- Sub, in_result=4'b1101 -> out_neg=1, out_digits=8'h03; Sub in_result=4'b1000 -> out_neg=1, 8'h08.
- Div, status=0, in_result=4'b0101 -> out_digits=8'h11 (rem 1, quot 1), out_err=0; Div status=1, in_result=4'b1111 -> out_err=1, out_digits=8'hFF.
- Backpressure: out_ready low for 10 clocks after out_valid -> outputs stable, in_ready=0, a second in_valid is ignored; out_ready high -> one transfer, in_ready=1 on the next clock.
- rst pulsed during the 2nd CONV cycle -> all outputs 0 immediately; after release, in_ready=1 and the next word converts correctly.
